// File: rtl/gb_bus_pkg.sv
// Shared bus types and address map for the CPU/memory side of the GB core.
package gb_bus_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {IDLE, START, XFER} dma_state_t;
  typedef enum logic [1:0] {MEM, HRAM, DMA_REG, BLOCKED} rd_src_t;

  localparam logic [15:0] ADDR_DMA_REG = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam logic [15:0] HRAM_BASE    = 16'hFF80;
  localparam logic [15:0] HRAM_LAST    = 16'hFFFE;

  function automatic logic is_hram(input logic [15:0] addr);
    return (addr >= HRAM_BASE) && (addr <= HRAM_LAST);
  endfunction

  // Source pages E0-FF alias the C0-DF work RAM (echo region).
  function automatic logic [7:0] src_eff(input logic [7:0] src);
    return (src >= 8'hE0) ? 8'(src - 8'h20) : src;
  endfunction

endpackage

// File: rtl/oam_dma_arbiter_if.sv
// CPU-side and memory-side bus bundle around the OAM DMA arbiter.
// master: CPU + memory environment; slave: the arbiter.
interface oam_dma_arbiter_if;
  import gb_bus_pkg::*;

  logic [ADDR_W-1:0] i_cpu_rd_addr;
  logic [DATA_W-1:0] o_cpu_rd_data;
  logic              i_cpu_wr_en;
  logic [ADDR_W-1:0] i_cpu_wr_addr;
  logic [DATA_W-1:0] i_cpu_wr_data;
  logic [ADDR_W-1:0] o_mem_rd_addr;
  logic [DATA_W-1:0] i_mem_rd_data;
  logic              o_mem_wr_en;
  logic [ADDR_W-1:0] o_mem_wr_addr;
  logic [DATA_W-1:0] o_mem_wr_data;
  logic              o_dma_active;

  modport master (
    output i_cpu_rd_addr, i_cpu_wr_en, i_cpu_wr_addr, i_cpu_wr_data, i_mem_rd_data,
    input  o_cpu_rd_data, o_mem_rd_addr, o_mem_wr_en, o_mem_wr_addr, o_mem_wr_data, o_dma_active
  );

  modport slave (
    input  i_cpu_rd_addr, i_cpu_wr_en, i_cpu_wr_addr, i_cpu_wr_data, i_mem_rd_data,
    output o_cpu_rd_data, o_mem_rd_addr, o_mem_wr_en, o_mem_wr_addr, o_mem_wr_data, o_dma_active
  );

endinterface

// File: rtl/oam_dma_arbiter_hram_ram.sv
// 127x8 high RAM (FF80-FFFE), synchronous write and registered read.
module hram_ram (
  input  logic       i_clk,
  input  logic       i_wr_en,
  input  logic [6:0] i_wr_addr,
  input  logic [7:0] i_wr_data,
  input  logic [6:0] i_rd_addr,
  output logic [7:0] o_rd_data
);
  localparam int unsigned HRAM_DEPTH = 127;

  logic [7:0] mem_q [HRAM_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem_q[i_wr_addr] <= i_wr_data;
    o_rd_data <= mem_q[i_rd_addr];
  end

endmodule

// File: rtl/oam_dma_arbiter.sv
// Shares the external memory port between the CPU and the FF46 OAM DMA engine.
// Build option OAM_DMA_HRAM_EN keeps FF80-FFFE HRAM inside this block.
module oam_dma_arbiter
  import gb_bus_pkg::*;
#(
  parameter int unsigned T_PER_M = 4,
  parameter int unsigned DMA_LEN = 160
) (
  input logic              i_clk,
  input logic              i_rst,
  oam_dma_arbiter_if.slave bus
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);
`ifdef OAM_DMA_HRAM_EN
  localparam bit HRAM_ON = 1'b1;
`else
  localparam bit HRAM_ON = 1'b0;
`endif

  if (T_PER_M != 4) begin : g_bad_t_per_m
    $error("oam_dma_arbiter: T_PER_M must be 4");
  end

  dma_state_t state_q, state_d;
  logic [1:0] t_q, t_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] src_q, src_d;
  logic [7:0] byte_q, byte_d;
  logic       active_q;
  rd_src_t    rd_cls_q, rd_cls_d;
  logic [7:0] hram_rdata;

  logic wr_dma_reg, wr_hram, rd_dma_reg, rd_hram;

  assign wr_dma_reg = bus.i_cpu_wr_en && (bus.i_cpu_wr_addr == ADDR_DMA_REG);
  assign wr_hram    = HRAM_ON && bus.i_cpu_wr_en && is_hram(bus.i_cpu_wr_addr);
  assign rd_dma_reg = (bus.i_cpu_rd_addr == ADDR_DMA_REG);
  assign rd_hram    = HRAM_ON && is_hram(bus.i_cpu_rd_addr);

`ifdef OAM_DMA_HRAM_EN
  hram_ram u_hram (
    .i_clk     (i_clk),
    .i_wr_en   (wr_hram),
    .i_wr_addr (bus.i_cpu_wr_addr[6:0]),
    .i_wr_data (bus.i_cpu_wr_data),
    .i_rd_addr (bus.i_cpu_rd_addr[6:0]),
    .o_rd_data (hram_rdata)
  );
`else
  assign hram_rdata = 8'hFF;
`endif

  // State and datapath registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      t_q      <= 2'd0;
      idx_q    <= 8'h00;
      src_q    <= 8'h00;
      byte_q   <= 8'h00;
      active_q <= 1'b0;
      rd_cls_q <= MEM;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      idx_q    <= idx_d;
      src_q    <= src_d;
      byte_q   <= byte_d;
      active_q <= (state_d != IDLE);
      rd_cls_q <= rd_cls_d;
    end
  end

  // Next state: an FF46 write (re)starts the copy from any state.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    idx_d   = idx_q;
    src_d   = src_q;
    byte_d  = byte_q;
    if (wr_dma_reg) begin
      src_d   = bus.i_cpu_wr_data;
      state_d = START;
      t_d     = 2'd0;
      idx_d   = 8'h00;
    end else begin
      case (state_q)
        START: begin
          t_d = t_q + 2'd1;
          if (t_q == 2'd3) state_d = XFER;
        end
        XFER: begin
          t_d = t_q + 2'd1;
          if (t_q == 2'd1) byte_d = bus.i_mem_rd_data;
          if (t_q == 2'd3) begin
            if (idx_q == LAST_IDX) begin
              state_d = IDLE;
              idx_d   = 8'h00;
            end else begin
              idx_d = idx_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Read class travels with the one-clock memory latency.
  always_comb begin
    rd_cls_d = MEM;
    if (rd_dma_reg)    rd_cls_d = DMA_REG;
    else if (rd_hram)  rd_cls_d = HRAM;
    else if (active_q) rd_cls_d = BLOCKED;
  end

  // Memory port: CPU passthrough in IDLE, DMA-only otherwise.
  always_comb begin
    bus.o_mem_rd_addr = 16'h0000;
    bus.o_mem_wr_en   = 1'b0;
    bus.o_mem_wr_addr = 16'h0000;
    bus.o_mem_wr_data = 8'h00;
    case (state_q)
      IDLE: begin
        bus.o_mem_rd_addr = (rd_dma_reg || rd_hram) ? 16'h0000 : bus.i_cpu_rd_addr;
        bus.o_mem_wr_en   = bus.i_cpu_wr_en && !wr_dma_reg && !wr_hram;
        bus.o_mem_wr_addr = bus.i_cpu_wr_addr;
        bus.o_mem_wr_data = bus.i_cpu_wr_data;
      end
      XFER: begin
        bus.o_mem_rd_addr = {src_eff(src_q), idx_q};
        bus.o_mem_wr_en   = (t_q == 2'd2);
        bus.o_mem_wr_addr = OAM_BASE + {8'h00, idx_q};
        bus.o_mem_wr_data = byte_q;
      end
      default: ;
    endcase
    // Reset kills the port at once, including a strobe already in flight.
    if (i_rst) begin
      bus.o_mem_rd_addr = 16'h0000;
      bus.o_mem_wr_en   = 1'b0;
      bus.o_mem_wr_addr = 16'h0000;
      bus.o_mem_wr_data = 8'h00;
    end
  end

  always_comb begin
    bus.o_cpu_rd_data = 8'h00;
    if (!i_rst) begin
      case (rd_cls_q)
        MEM:     bus.o_cpu_rd_data = bus.i_mem_rd_data;
        HRAM:    bus.o_cpu_rd_data = hram_rdata;
        DMA_REG: bus.o_cpu_rd_data = src_q;
        default: bus.o_cpu_rd_data = 8'hFF;
      endcase
    end
  end

  assign bus.o_dma_active = active_q;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Randomized self-checking bench for oam_dma_arbiter against a byte-array memory reference.
module tb_oam_dma_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  oam_dma_arbiter_if bus ();
  oam_dma_arbiter #(.T_PER_M(4), .DMA_LEN(160)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_ev_t;

  wr_ev_t   wlog[$];
  bit [7:0] mem [65536];
  bit [7:0] ref_mem [65536];
  int cyc = 0;
  int active_edges = 0;
  int last_ff46 = 0;
  int ff90_hits = 0;
  int n_checks = 0;
  int n_pass = 0;

  // External memory with 1-clock read latency, plus port activity logging.
  always @(posedge clk) begin
    if (bus.o_mem_wr_en) begin
      wlog.push_back('{cyc, bus.o_mem_wr_addr, bus.o_mem_wr_data});
      mem[bus.o_mem_wr_addr] <= bus.o_mem_wr_data;
    end
    bus.i_mem_rd_data <= mem[bus.o_mem_rd_addr];
    if (bus.o_dma_active) active_edges <= active_edges + 1;
    if (bus.i_cpu_wr_en && bus.i_cpu_wr_addr == 16'hFF46) last_ff46 <= cyc;
    if (bus.o_mem_rd_addr == 16'hFF90 || (bus.o_mem_wr_en && bus.o_mem_wr_addr == 16'hFF90))
      ff90_hits <= ff90_hits + 1;
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input bit lands);
    bus.i_cpu_wr_en   = 1'b1;
    bus.i_cpu_wr_addr = a;
    bus.i_cpu_wr_data = d;
    tick();
    bus.i_cpu_wr_en = 1'b0;
    if (lands) ref_mem[a] = d;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    bus.i_cpu_rd_addr = a;
    tick();
    d = bus.o_cpu_rd_data;
    bus.i_cpu_rd_addr = 16'h0000;
  endtask

  function automatic logic [7:0] eff_page(input logic [7:0] s);
    return (s >= 8'hE0) ? 8'(s - 8'h20) : s;
  endfunction

  function automatic int count_after(input int e);
    int c = 0;
    foreach (wlog[j]) if (wlog[j].cyc > e) c++;
    return c;
  endfunction

  task automatic preload(input logic [7:0] page, input bit pattern, input int n);
    for (int i = 0; i < n; i++)
      cpu_write({page, 8'(i)}, pattern ? 8'(i ^ 8'hA5) : 8'($urandom), 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.o_dma_active && n < budget) begin tick(); n++; end
    check("dma_done_in_time", 32'(bus.o_dma_active), 32'd0);
  endtask

  task automatic wait_writes(input int e, input int n, input int budget);
    int k = 0;
    while (count_after(e) < n && k < budget) begin tick(); k++; end
    check("oam_writes_in_time", 32'(count_after(e) >= n), 32'd1);
  endtask

  // Expected OAM traffic: byte k lands at FE00+k, 4 clocks apart, first one 7 clocks after the FF46 edge.
  task automatic check_oam(input int e, input logic [7:0] page, input int n, input string tag);
    int k = 0;
    foreach (wlog[j]) begin
      if (wlog[j].cyc > e) begin
        if (k < n) begin
          check({tag, "_addr"}, 32'(wlog[j].addr), 32'(16'hFE00 + 16'(k)));
          check({tag, "_data"}, 32'(wlog[j].data), 32'(ref_mem[{page, 8'(k)}]));
          check({tag, "_time"}, 32'(wlog[j].cyc - e), 32'(7 + 4 * k));
        end
        k++;
      end
    end
    check({tag, "_count"}, 32'(k), 32'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  d;
    logic [7:0]  src;
    logic [15:0] a;
    logic [15:0] waddr [$];
    int e0, er, a0, h0, n0, n;

    bus.i_cpu_rd_addr = 16'h0000;
    bus.i_cpu_wr_en   = 1'b0;
    bus.i_cpu_wr_addr = 16'h0000;
    bus.i_cpu_wr_data = 8'h00;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_dma_active", 32'(bus.o_dma_active), 32'd0);
    check("rst_mem_wr_en", 32'(bus.o_mem_wr_en), 32'd0);
    check("rst_mem_rd_addr", 32'(bus.o_mem_rd_addr), 32'd0);
    check("rst_mem_wr_addr", 32'(bus.o_mem_wr_addr), 32'd0);
    check("rst_cpu_rd_data", 32'(bus.o_cpu_rd_data), 32'd0);
    rst = 1'b0;
    tick();

    // Idle passthrough
    bus.i_cpu_wr_en = 1'b1; bus.i_cpu_wr_addr = 16'hC000; bus.i_cpu_wr_data = 8'h5A;
    #1;
    check("idle_wr_en", 32'(bus.o_mem_wr_en), 32'd1);
    check("idle_wr_addr", 32'(bus.o_mem_wr_addr), 32'hC000);
    check("idle_wr_data", 32'(bus.o_mem_wr_data), 32'h5A);
    tick();
    bus.i_cpu_wr_en = 1'b0;
    ref_mem[16'hC000] = 8'h5A;
    cpu_read(16'hC000, d);
    check("idle_rd_c000", 32'(d), 32'h5A);

    for (int i = 0; i < 12; i++) begin
      a = 16'($urandom_range(0, 16'hDFFF));
      waddr.push_back(a);
      cpu_write(a, 8'($urandom), 1'b1);
    end
    for (int i = 0; i < 12; i++) begin
      a = waddr[$urandom_range(0, 11)];
      cpu_read(a, d);
      check("idle_rand_rd", 32'(d), 32'(ref_mem[a]));
    end

    // DMA from C000 with lockout probes
    preload(8'hC0, 1'b1, 160);
    a0 = active_edges;
    cpu_write(16'hFF46, 8'hC0, 1'b0);
    e0 = last_ff46;
    check("dma_active_rise", 32'(bus.o_dma_active), 32'd1);
    cpu_read(16'h8000, d);
    check("lock_rd_8000", 32'(d), 32'hFF);
    cpu_write(16'hC100, 8'h77, 1'b0);
    cpu_read(16'hFF46, d);
    check("ff46_readback", 32'(d), 32'hC0);
    for (int i = 0; i < 6; i++) begin
      cpu_read(16'($urandom_range(0, 16'hFEFF)), d);
      check("lock_rd_rand", 32'(d), 32'hFF);
    end
    wait_idle(800);
    check("active_len", 32'(active_edges - a0), 32'd644);
    check_oam(e0, 8'hC0, 160, "dma_c0");
    cpu_read(16'hC100, d);
    check("lock_wr_dropped", 32'(d), 32'(ref_mem[16'hC100]));

    // Restart at byte 50
    preload(8'hD0, 1'b0, 160);
    a0 = active_edges;
    cpu_write(16'hFF46, 8'hC0, 1'b0);
    e0 = last_ff46;
    wait_writes(e0, 50, 400);
    cpu_write(16'hFF46, 8'hD0, 1'b0);
    er = last_ff46;
    check("restart_pre_count", 32'(count_after(e0) - count_after(er)), 32'd50);
    check("restart_active", 32'(bus.o_dma_active), 32'd1);
    wait_idle(800);
    check("restart_active_len", 32'(active_edges - a0), 32'((er - e0) + 644));
    check_oam(er, 8'hD0, 160, "restart");

    // Random sources, one forced into the echo range
    for (int r = 0; r < 2; r++) begin
      src = (r == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(8'hE0, 8'hFF));
      preload(eff_page(src), 1'b0, 160);
      a0 = active_edges;
      cpu_write(16'hFF46, src, 1'b0);
      e0 = last_ff46;
      cpu_read(16'hFF46, d);
      check("rand_ff46_raw", 32'(d), 32'(src));
      wait_idle(800);
      check("rand_active_len", 32'(active_edges - a0), 32'd644);
      check_oam(e0, eff_page(src), 160, "rand_dma");
    end

    // Echo source then asynchronous reset mid-transfer
    preload(8'hC1, 1'b0, 16);
    cpu_write(16'hFF46, 8'hE1, 1'b0);
    e0 = last_ff46;
    wait_writes(e0, 10, 200);
    check_oam(e0, 8'hC1, 10, "echo");
    n = 0;
    while (!bus.o_mem_wr_en && n < 8) begin tick(); n++; end
    check("echo_strobe_before_rst", 32'(bus.o_mem_wr_en), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_active", 32'(bus.o_dma_active), 32'd0);
    check("async_rst_wr_en", 32'(bus.o_mem_wr_en), 32'd0);
    n0 = wlog.size();
    a0 = active_edges;
    repeat (2) tick();
    rst = 1'b0;
    repeat (700) tick();
    check("rst_no_more_writes", 32'(wlog.size()), 32'(n0));
    check("rst_active_low", 32'(active_edges - a0), 32'd0);

    // HRAM at FF90
    cpu_write(16'hFF46, 8'hC0, 1'b0);
    h0 = ff90_hits;
    cpu_write(16'hFF90, 8'h3C, 1'b0);
    cpu_read(16'hFF90, d);
`ifdef OAM_DMA_HRAM_EN
    check("hram_rd_during_dma", 32'(d), 32'h3C);
    wait_idle(800);
    check("hram_no_port_dma", 32'(ff90_hits - h0), 32'd0);
    cpu_read(16'hFF90, d);
    check("hram_rd_idle", 32'(d), 32'h3C);
    check("hram_no_port_idle", 32'(ff90_hits - h0), 32'd0);
`else
    check("hram_blocked_rd", 32'(d), 32'hFF);
    wait_idle(800);
    check("hram_blocked_no_port", 32'(ff90_hits - h0), 32'd0);
    cpu_read(16'hFF90, d);
    check("hram_wr_dropped", 32'(d), 32'(ref_mem[16'hFF90]));
    cpu_write(16'hFF90, 8'h3C, 1'b1);
    check("hram_idle_passthrough", 32'(ff90_hits - h0 > 0), 32'd1);
    cpu_read(16'hFF90, d);
    check("hram_idle_rd", 32'(d), 32'h3C);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
